// File: rtl/cam_sccb_pkg.sv
// cam_sccb_pkg: shared definitions for the camera SCCB init master.
//   - state_t        : controller state encoding
//   - bus constants  : quarters per bit, bytes per word, bits per byte, retries
//   - word fields    : byte slice positions inside a 32-bit ROM command word
//   - word_empty()   : detects the all-zero terminator word
package cam_sccb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_FETCH = 4'd1,
    ST_CHECK = 4'd2,
    ST_START = 4'd3,
    ST_BIT   = 4'd4,
    ST_ACK   = 4'd5,
    ST_STOP  = 4'd6,
    ST_GAP   = 4'd7,
    ST_FIN   = 4'd8
  } state_t;

  localparam int QUARTERS_PER_BIT = 4;
  localparam int BYTES_PER_WORD   = 4;
  localparam int BITS_PER_BYTE    = 8;
  localparam int MAX_RETRY        = 3;

  localparam int WORD_W   = 32;
  localparam int BYTE_W   = 8;
  localparam int DEV_LSB  = 24;  // device write address
  localparam int REGH_LSB = 16;  // register address high byte
  localparam int REGL_LSB = 8;   // register address low byte
  localparam int DATA_LSB = 0;   // register data

  function automatic logic word_empty(input logic [WORD_W-1:0] w);
    return (w[DEV_LSB  +: BYTE_W] == '0) && (w[REGH_LSB +: BYTE_W] == '0) &&
           (w[REGL_LSB +: BYTE_W] == '0) && (w[DATA_LSB +: BYTE_W] == '0);
  endfunction

endpackage

// File: rtl/cam_sccb_qtick.sv
// cam_sccb_qtick: SCL quarter-period tick generator.
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr          : synchronous restart of the count (wins over en)
//   en           : count enable
//   tick         : one-cycle pulse every CLK_DIV enabled cycles
module cam_sccb_qtick #(
  parameter int unsigned CLK_DIV = 63
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic tick
);

  logic [9:0] cnt;

  assign tick = en && (cnt == 10'(CLK_DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? 10'd0 : cnt + 10'd1;
    end
  end

endmodule

// File: rtl/cam_sccb_master.sv
// cam_sccb_master: walks the camera init ROM from address 0 and sends each
// 32-bit word as a 4-byte SCCB write (dev addr, reg hi, reg lo, data),
// MSB first, over open-drain SCL/SDA. Stops on the ROM final flag, on an
// all-zero word, or after the word at address 0xFF.
//   clk_i, rst_i            : clock, synchronous active-high reset
//   start_i                 : pulse, starts the sequence when idle
//   rom_addr_o              : ROM address
//   rom_data_i, rom_final_i : ROM word and last-entry flag, 1 cycle latency
//   scl_o                   : SCL level (1 = released)
//   sda_oe_o, sda_i         : SDA pull-low enable, sampled SDA pin
//   busy_o, done_o, err_o   : in progress, sticky complete, sticky NACK error
// Build option: define CAM_SCCB_ACK_CHECK_EN to treat a high ACK sample as a
// NACK, retry the word up to 3 attempts and flag err_o on final failure.
// Without it ACK samples are ignored and err_o stays 0.
module cam_sccb_master
  import cam_sccb_pkg::*;
#(
  parameter int unsigned CLK_DIV          = 63,
  parameter int unsigned GAP_CYCLES       = 1000,
  parameter int unsigned FIRST_GAP_CYCLES = 250000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [7:0]  rom_addr_o,
  input  logic [31:0] rom_data_i,
  input  logic        rom_final_i,
  output logic        scl_o,
  output logic        sda_oe_o,
  input  logic        sda_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o
);

`ifdef CAM_SCCB_ACK_CHECK_EN
  localparam bit ACK_CHECK = 1'b1;
`else
  localparam bit ACK_CHECK = 1'b0;
`endif

  state_t            state;
  logic [1:0]        q;
  logic [2:0]        bit_cnt;
  logic [1:0]        byte_cnt;
  logic [1:0]        retry_cnt;
  logic              fetch_cnt;
  logic [31:0]       gap_cnt;
  logic [31:0]       gap_len;
  logic [WORD_W-1:0] shreg;
  logic              last_q;
  logic              nack_q;
  logic              retry_pend;
  logic [7:0]        rom_addr_q;
  logic              busy_q, done_q, err_q;
  logic              in_bus, qclr, tick, q_last;

  function automatic logic [7:0] addr_sat_inc(input logic [7:0] a);
    return (a == 8'hFF) ? a : a + 8'd1;
  endfunction

  assign rom_addr_o = rom_addr_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

  assign in_bus = (state == ST_START) || (state == ST_BIT) ||
                  (state == ST_ACK)   || (state == ST_STOP);
  // Bus-state changes only happen on a tick, where the counter wraps to 0,
  // so holding it clear outside the bus states restarts it on every entry.
  assign qclr   = ~in_bus;
  assign q_last = (q == 2'(QUARTERS_PER_BIT - 1));

  // A retry always uses the short gap; word 0 otherwise gets the settle gap.
  assign gap_len = (retry_pend || (rom_addr_q != 8'd0)) ? 32'(GAP_CYCLES)
                                                        : 32'(FIRST_GAP_CYCLES);

  cam_sccb_qtick #(.CLK_DIV(CLK_DIV)) u_qtick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (qclr),
    .en    (in_bus),
    .tick  (tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      q          <= '0;
      bit_cnt    <= '0;
      byte_cnt   <= '0;
      retry_cnt  <= '0;
      fetch_cnt  <= 1'b0;
      gap_cnt    <= '0;
      rom_addr_q <= '0;
      last_q     <= 1'b0;
      nack_q     <= 1'b0;
      retry_pend <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          done_q     <= 1'b0;
          err_q      <= 1'b0;
          busy_q     <= 1'b1;
          rom_addr_q <= '0;
          fetch_cnt  <= 1'b0;
          retry_cnt  <= '0;
          retry_pend <= 1'b0;
          state      <= ST_FETCH;
        end
        ST_FETCH: begin
          fetch_cnt <= ~fetch_cnt;
          if (fetch_cnt) begin
            // The last ROM address acts as final even without the flag.
            last_q <= rom_final_i || (rom_addr_q == 8'hFF);
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          q        <= '0;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          nack_q   <= 1'b0;
          state    <= word_empty(shreg) ? ST_FIN : ST_START;
        end
        ST_START: if (tick) begin
          q <= q + 2'd1;
          if (q_last) state <= ST_BIT;
        end
        ST_BIT: if (tick) begin
          q <= q + 2'd1;
          if (q_last) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'(BITS_PER_BYTE - 1)) state <= ST_ACK;
          end
        end
        ST_ACK: if (tick) begin
          q <= q + 2'd1;
          if (q == 2'd2) nack_q <= nack_q | sda_i;
          if (q_last) begin
            byte_cnt <= byte_cnt + 2'd1;
            state    <= (byte_cnt == 2'(BYTES_PER_WORD - 1)) ? ST_STOP : ST_BIT;
          end
        end
        ST_STOP: if (tick) begin
          q <= q + 2'd1;
          if (q_last) begin
            gap_cnt <= '0;
            if (ACK_CHECK && nack_q) begin
              if (retry_cnt == 2'(MAX_RETRY - 1)) begin
                err_q  <= 1'b1;
                busy_q <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                retry_cnt  <= retry_cnt + 2'd1;
                retry_pend <= 1'b1;
                state      <= ST_GAP;
              end
            end else begin
              retry_cnt  <= '0;
              retry_pend <= 1'b0;
              state      <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == gap_len - 32'd1) begin
            gap_cnt <= '0;
            if (retry_pend) begin
              state <= ST_FETCH;
            end else if (last_q) begin
              state <= ST_FIN;
            end else begin
              rom_addr_q <= addr_sat_inc(rom_addr_q);
              state      <= ST_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + 32'd1;
          end
        end
        ST_FIN: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Command word: loaded at the end of FETCH, shifted MSB-first per bit.
  always_ff @(posedge clk_i) begin
    if ((state == ST_FETCH) && fetch_cnt) begin
      shreg <= rom_data_i;
    end else if ((state == ST_BIT) && tick && q_last) begin
      shreg <= {shreg[WORD_W-2:0], 1'b0};
    end
  end

  // Pin levels decoded from registered state only; reset releases the bus.
  always_comb begin
    scl_o    = 1'b1;
    sda_oe_o = 1'b0;
    case (state)
      ST_START: begin
        scl_o    = (q != 2'd3);
        sda_oe_o = (q != 2'd0);
      end
      ST_BIT: begin
        scl_o    = (q == 2'd1) || (q == 2'd2);
        sda_oe_o = ~shreg[WORD_W-1];
      end
      ST_ACK: scl_o = (q == 2'd1) || (q == 2'd2);
      ST_STOP: begin
        scl_o    = (q != 2'd0);
        sda_oe_o = (q == 2'd0) || (q == 2'd1);
      end
      default: ;
    endcase
  end

endmodule
